// File: rtl/in_decode_pkg.sv
// Shared decode definitions for the RV32I ID stage: opcodes, ALU/jump encodings,
// the control bundle, the ID/EX record and the immediate generator.
package in_decode_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int RIDX = $clog2(NREG);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // ALUOp is {funct7[5], funct3}; the named values below are the common points.
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    typedef enum logic [1:0] {
        JUMP_NONE = 2'b00,
        JUMP_JAL  = 2'b01,
        JUMP_JALR = 2'b10
    } jump_e;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       branch;
        jump_e      jump;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = ctrl_t'('0);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [RIDX-1:0] rs1;
        logic [RIDX-1:0] rs2;
        logic [RIDX-1:0] rd;
        ctrl_t           ctrl;
    } idex_t;

    localparam idex_t IDEX_BUBBLE = idex_t'('0);

    // B and J immediates are byte offsets with bit 0 forced to zero.
    function automatic logic [XLEN-1:0] gen_imm(input logic [31:0] inst, input imm_fmt_e fmt);
        logic [XLEN-1:0] imm;
        imm = '0;
        case (fmt)
            IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   imm = {inst[31:12], 12'b0};
            IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/in_decode_reg_file.sv
// 2-read/1-write architectural register file. x0 reads as zero and is never
// written; a same-cycle write to a read register is bypassed to the read port.
module in_decode_reg_file
    import in_decode_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we_i,
    input  logic [RIDX-1:0] waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [RIDX-1:0] raddr1_i,
    input  logic [RIDX-1:0] raddr2_i,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o
);

    logic [XLEN-1:0] regs_q [NREG];
    logic            wr_en;

    assign wr_en = we_i && (waddr_i != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    function automatic logic [XLEN-1:0] read_port(input logic [RIDX-1:0] addr);
        logic [XLEN-1:0] data;
        if (addr == '0) begin
            data = '0;
        end else if (wr_en && (waddr_i == addr)) begin
            data = wdata_i;
        end else begin
            data = regs_q[addr];
        end
        return data;
    endfunction

    assign rdata1_o = read_port(raddr1_i);
    assign rdata2_o = read_port(raddr2_i);

endmodule

// File: rtl/in_decode.sv
// RV32I decode stage: control/immediate decode, register read, load-use
// hazard detection and the ID/EX pipeline register.
module in_decode
    import in_decode_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction_in,
    input  logic [31:0] PC_in,
    input  logic        PCSrc,
    input  logic        wb_RegWrite,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        PCWrite,
    output logic [31:0] ex_PC,
    output logic [31:0] ex_rs1_data,
    output logic [31:0] ex_rs2_data,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2,
    output logic [4:0]  ex_rd,
    output logic [3:0]  ex_ALUOp,
    output logic        ex_ALUSrc,
    output logic        ex_MemRead,
    output logic        ex_MemWrite,
    output logic        ex_RegWrite,
    output logic        ex_MemtoReg,
    output logic        ex_Branch,
    output logic [1:0]  ex_Jump
);

    idex_t           ex_q;
    idex_t           ex_d;
    ctrl_t           ctrl;
    imm_fmt_e        imm_fmt;
    logic            use_rs1;
    logic            use_rs2;
    logic            has_rd;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7_b5;
    logic [RIDX-1:0] rs1_idx;
    logic [RIDX-1:0] rs2_idx;
    logic [RIDX-1:0] rd_idx;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            load_use;

    assign opcode    = instruction_in[6:0];
    assign funct3    = instruction_in[14:12];
    assign funct7_b5 = instruction_in[30];

    always_comb begin
        ctrl    = CTRL_NOP;
        imm_fmt = IMM_NONE;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        has_rd  = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                has_rd         = 1'b1;
                imm_fmt        = IMM_U;
            end
            OPC_JAL: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.jump      = JUMP_JAL;
                has_rd         = 1'b1;
                imm_fmt        = IMM_J;
            end
            OPC_JALR: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.jump      = JUMP_JALR;
                use_rs1        = 1'b1;
                has_rd         = 1'b1;
                imm_fmt        = IMM_I;
            end
            OPC_BRANCH: begin
                ctrl.alu_op = ALU_SUB;
                ctrl.branch = 1'b1;
                use_rs1     = 1'b1;
                use_rs2     = 1'b1;
                imm_fmt     = IMM_B;
            end
            OPC_LOAD: begin
                ctrl.alu_src    = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                use_rs1         = 1'b1;
                has_rd          = 1'b1;
                imm_fmt         = IMM_I;
            end
            OPC_STORE: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                use_rs1        = 1'b1;
                use_rs2        = 1'b1;
                imm_fmt        = IMM_S;
            end
            OPC_OPIMM: begin
                // funct7[5] only distinguishes SRAI from SRLI; other OP-IMM
                // encodings carry immediate bits there.
                ctrl.alu_op    = {funct7_b5 && (funct3 == 3'b001 || funct3 == 3'b101), funct3};
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                use_rs1        = 1'b1;
                has_rd         = 1'b1;
                imm_fmt        = IMM_I;
            end
            OPC_OP: begin
                ctrl.alu_op    = {funct7_b5, funct3};
                ctrl.reg_write = 1'b1;
                use_rs1        = 1'b1;
                use_rs2        = 1'b1;
                has_rd         = 1'b1;
            end
            default: begin
                ctrl = CTRL_NOP;
            end
        endcase
    end

    // Unused fields read as index 0 so they neither fetch data nor match a hazard.
    assign rs1_idx = use_rs1 ? instruction_in[19:15] : '0;
    assign rs2_idx = use_rs2 ? instruction_in[24:20] : '0;
    assign rd_idx  = has_rd  ? instruction_in[11:7]  : '0;

    in_decode_reg_file u_reg_file (
        .clk      (clk),
        .rst_n    (reset),
        .we_i     (wb_RegWrite),
        .waddr_i  (wb_rd),
        .wdata_i  (wb_data),
        .raddr1_i (rs1_idx),
        .raddr2_i (rs2_idx),
        .rdata1_o (rs1_data),
        .rdata2_o (rs2_data)
    );

    assign load_use = ex_q.ctrl.mem_read && (ex_q.rd != '0)
                   && ((ex_q.rd == rs1_idx) || (ex_q.rd == rs2_idx));

    assign PCWrite = load_use && !PCSrc && reset;

    always_comb begin
        ex_d = IDEX_BUBBLE;
        if (!PCSrc && !load_use) begin
            ex_d.pc       = PC_in;
            ex_d.rs1_data = rs1_data;
            ex_d.rs2_data = rs2_data;
            ex_d.imm      = gen_imm(instruction_in, imm_fmt);
            ex_d.rs1      = rs1_idx;
            ex_d.rs2      = rs2_idx;
            ex_d.rd       = rd_idx;
            ex_d.ctrl     = ctrl;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q <= IDEX_BUBBLE;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign ex_PC       = ex_q.pc;
    assign ex_rs1_data = ex_q.rs1_data;
    assign ex_rs2_data = ex_q.rs2_data;
    assign ex_imm      = ex_q.imm;
    assign ex_rs1      = ex_q.rs1;
    assign ex_rs2      = ex_q.rs2;
    assign ex_rd       = ex_q.rd;
    assign ex_ALUOp    = ex_q.ctrl.alu_op;
    assign ex_ALUSrc   = ex_q.ctrl.alu_src;
    assign ex_MemRead  = ex_q.ctrl.mem_read;
    assign ex_MemWrite = ex_q.ctrl.mem_write;
    assign ex_RegWrite = ex_q.ctrl.reg_write;
    assign ex_MemtoReg = ex_q.ctrl.mem_to_reg;
    assign ex_Branch   = ex_q.ctrl.branch;
    assign ex_Jump     = ex_q.ctrl.jump;

endmodule

// File: tb/tb_in_decode.sv
// Directed bench for in_decode: a decode vector table plus hand sequences for
// load-use stall, flush, register bypass and mid-stream reset.
module tb_in_decode;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction_in;
    logic [31:0] PC_in;
    logic        PCSrc;
    logic        wb_RegWrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        PCWrite;
    logic [31:0] ex_PC, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [3:0]  ex_ALUOp;
    logic        ex_ALUSrc, ex_MemRead, ex_MemWrite, ex_RegWrite, ex_MemtoReg, ex_Branch;
    logic [1:0]  ex_Jump;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    in_decode dut (
        .clk            (clk),
        .reset          (reset),
        .instruction_in (instruction_in),
        .PC_in          (PC_in),
        .PCSrc          (PCSrc),
        .wb_RegWrite    (wb_RegWrite),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .PCWrite        (PCWrite),
        .ex_PC          (ex_PC),
        .ex_rs1_data    (ex_rs1_data),
        .ex_rs2_data    (ex_rs2_data),
        .ex_imm         (ex_imm),
        .ex_rs1         (ex_rs1),
        .ex_rs2         (ex_rs2),
        .ex_rd          (ex_rd),
        .ex_ALUOp       (ex_ALUOp),
        .ex_ALUSrc      (ex_ALUSrc),
        .ex_MemRead     (ex_MemRead),
        .ex_MemWrite    (ex_MemWrite),
        .ex_RegWrite    (ex_RegWrite),
        .ex_MemtoReg    (ex_MemtoReg),
        .ex_Branch      (ex_Branch),
        .ex_Jump        (ex_Jump)
    );

    // {ALUOp, ALUSrc, MemRead, MemWrite, RegWrite, MemtoReg, Branch, Jump}
    function automatic logic [11:0] ctrl_now();
        return {ex_ALUOp, ex_ALUSrc, ex_MemRead, ex_MemWrite, ex_RegWrite,
                ex_MemtoReg, ex_Branch, ex_Jump};
    endfunction

    function automatic logic [14:0] idx_now();
        return {ex_rd, ex_rs1, ex_rs2};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_bubble(input string name);
        chk({name, ".ctrl"}, 64'(ctrl_now()), 64'd0);
        chk({name, ".idx"},  64'(idx_now()),  64'd0);
        chk({name, ".imm"},  64'(ex_imm),     64'd0);
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [11:0] ctrl;
        logic [14:0] idx;   // {rd, rs1, rs2}
    } vec_t;

    vec_t vecs [13];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'hFFD00093, 32'hFFFFFFFD, 12'b0000_100100_00, {5'd1, 5'd0, 5'd0}}; // ADDI x1,x0,-3
        vecs[1]  = '{32'h001000EF, 32'h00000800, 12'b0000_100100_01, {5'd1, 5'd0, 5'd0}}; // JAL x1,+2048
        vecs[2]  = '{32'h00000000, 32'h00000000, 12'b0000_000000_00, {5'd0, 5'd0, 5'd0}}; // bubble
        vecs[3]  = '{32'h123452B7, 32'h12345000, 12'b0000_100100_00, {5'd5, 5'd0, 5'd0}}; // LUI x5
        vecs[4]  = '{32'hFFFFF317, 32'hFFFFF000, 12'b0000_100100_00, {5'd6, 5'd0, 5'd0}}; // AUIPC x6
        vecs[5]  = '{32'h008100E7, 32'h00000008, 12'b0000_100100_10, {5'd1, 5'd2, 5'd0}}; // JALR x1,8(x2)
        vecs[6]  = '{32'hFE312E23, 32'hFFFFFFFC, 12'b0000_101000_00, {5'd0, 5'd2, 5'd3}}; // SW x3,-4(x2)
        vecs[7]  = '{32'hFE208CE3, 32'hFFFFFFF8, 12'b1000_000001_00, {5'd0, 5'd1, 5'd2}}; // BEQ x1,x2,-8
        vecs[8]  = '{32'h407302B3, 32'h00000000, 12'b1000_000100_00, {5'd5, 5'd6, 5'd7}}; // SUB x5,x6,x7
        vecs[9]  = '{32'h40325213, 32'h00000403, 12'b1101_100100_00, {5'd4, 5'd4, 5'd0}}; // SRAI x4,x4,3
        vecs[10] = '{32'hFFF0C493, 32'hFFFFFFFF, 12'b0100_100100_00, {5'd9, 5'd1, 5'd0}}; // XORI x9,x1,-1
        vecs[11] = '{32'h0000A103, 32'h00000000, 12'b0000_110110_00, {5'd2, 5'd1, 5'd0}}; // LW x2,0(x1)
        vecs[12] = '{32'h00000000, 32'h00000000, 12'b0000_000000_00, {5'd0, 5'd0, 5'd0}}; // bubble

        reset          = 1'b0;
        instruction_in = 32'h0;
        PC_in          = 32'h0;
        PCSrc          = 1'b0;
        wb_RegWrite    = 1'b0;
        wb_rd          = 5'd0;
        wb_data        = 32'h0;
        tick();
        tick();
        chk("reset.ctrl", 64'(ctrl_now()), 64'd0);
        chk("reset.pc", 64'(ex_PC), 64'd0);
        chk("reset.pcwrite", 64'(PCWrite), 64'd0);
        reset = 1'b1;
        tick();

        // Decode table
        for (int i = 0; i < 13; i++) begin
            instruction_in = vecs[i].instr;
            PC_in          = 32'h1000 + 32'(i * 4);
            #1;
            chk($sformatf("vec%0d.pcwrite", i), 64'(PCWrite), 64'd0);
            tick();
            chk($sformatf("vec%0d.imm", i),  64'(ex_imm),     64'(vecs[i].imm));
            chk($sformatf("vec%0d.ctrl", i), 64'(ctrl_now()), 64'(vecs[i].ctrl));
            chk($sformatf("vec%0d.idx", i),  64'(idx_now()),  64'(vecs[i].idx));
            chk($sformatf("vec%0d.pc", i),   64'(ex_PC),      64'(32'h1000 + 32'(i * 4)));
        end

        // Load-use: LW x2,0(x1) then ADD x3,x2,x4
        instruction_in = 32'h0000A103;
        PC_in          = 32'h2000;
        tick();
        instruction_in = 32'h004101B3;
        PC_in          = 32'h2004;
        #1;
        chk("lu.pcwrite_stall", 64'(PCWrite), 64'd1);
        tick();
        chk_bubble("lu.bubble");
        chk("lu.pcwrite_release", 64'(PCWrite), 64'd0);
        tick();
        chk("lu.add_idx", 64'(idx_now()), 64'({5'd3, 5'd2, 5'd4}));
        chk("lu.add_ctrl", 64'(ctrl_now()), 64'(12'b0000_000100_00));
        chk("lu.add_pc", 64'(ex_PC), 64'h2004);

        // Flush coincident with load-use
        instruction_in = 32'h0000A103;
        PC_in          = 32'h3000;
        tick();
        instruction_in = 32'h004101B3;
        PC_in          = 32'h3004;
        PCSrc          = 1'b1;
        #1;
        chk("flush.pcwrite", 64'(PCWrite), 64'd0);
        tick();
        PCSrc = 1'b0;
        chk_bubble("flush.bubble");
        chk("flush.pc", 64'(ex_PC), 64'd0);

        // Write-through bypass: ADD x8,x7,x0 while x7 <= 0x1234
        instruction_in = 32'h00038433;
        wb_RegWrite    = 1'b1;
        wb_rd          = 5'd7;
        wb_data        = 32'h1234;
        tick();
        chk("byp.rs1_data", 64'(ex_rs1_data), 64'h1234);
        // ADD x8,x0,x0 with wb_rd=0: x0 must stay zero
        instruction_in = 32'h00000433;
        wb_rd          = 5'd0;
        wb_data        = 32'hCAFE;
        tick();
        chk("byp.x0_rs1", 64'(ex_rs1_data), 64'd0);
        wb_RegWrite    = 1'b0;
        tick();
        chk("byp.x0_after", 64'(ex_rs1_data), 64'd0);
        // ADD x8,x0,x7: x7 retained the written value
        instruction_in = 32'h00700433;
        tick();
        chk("byp.x7_rs2", 64'(ex_rs2_data), 64'h1234);

        // Mid-stream reset: load x5, see it decoded, then reset clears everything
        instruction_in = 32'h0;
        wb_RegWrite    = 1'b1;
        wb_rd          = 5'd5;
        wb_data        = 32'hDEAD;
        tick();
        wb_RegWrite    = 1'b0;
        instruction_in = 32'h00028333;
        PC_in          = 32'h4000;
        tick();
        chk("rst.pre_x5", 64'(ex_rs1_data), 64'hDEAD);
        reset = 1'b0;
        #1;
        chk("rst.async_ctrl", 64'(ctrl_now()), 64'd0);
        chk("rst.async_data", 64'({ex_rs1_data, ex_PC}), 64'd0);
        chk("rst.async_idx", 64'(idx_now()), 64'd0);
        chk("rst.pcwrite", 64'(PCWrite), 64'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("rst.x5_cleared", 64'(ex_rs1_data), 64'd0);
        chk("rst.x5_idx", 64'(idx_now()), 64'({5'd6, 5'd5, 5'd0}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
